// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares a single RAM port between the icache fill port and the dcache
// fill/writeback port of one CPU. One requester is granted at a time and the
// grant is held until the RAM reports ACCESS, reports ERROR, times out, or the
// requester withdraws. dcache has priority; a starvation counter forces an
// icache grant after STARVE_LIMIT consecutive dcache grants taken while iREN
// was pending. Every transaction is followed by one IDLE turnaround cycle.
//
// Optional build macro:
//   MEM_ARB_STATS_EN  adds saturating counters igrants/dgrants/aborts.
//
// Parameters:
//   STARVE_LIMIT  dcache grants allowed while iREN waits (must fit in CW bits)
//   TIMEOUT       grant cycles without ACCESS before the grant is aborted
//   CW            width of the timeout, starvation and stats counters
//
// Ports:
//   CLK, nRST             clock, synchronous active-low reset
//   iREN, iaddr           icache read request / word address
//   iwait, iload          icache wait (low one cycle on completion) / data
//   dREN, dWEN            dcache read / write request (write wins)
//   daddr, dstore         dcache word address / write data
//   dwait, dload          dcache wait (low one cycle on completion) / data
//   ramREN, ramWEN        RAM read / write enable
//   ramaddr, ramstore     RAM address / write data
//   ramload, ramstate     RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   merr                  sticky error flag (RAM ERROR or timeout)
//   igrants, dgrants,     completed transactions per requester and aborted
//   aborts                grants (MEM_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned CW           = 8
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iREN,
    input  logic [31:0]   iaddr,
    output logic          iwait,
    output logic [31:0]   iload,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [31:0]   daddr,
    input  logic [31:0]   dstore,
    output logic          dwait,
    output logic [31:0]   dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [31:0]   ramaddr,
    output logic [31:0]   ramstore,
    input  logic [31:0]   ramload,
    input  logic [1:0]    ramstate,
    output logic          merr
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [CW-1:0] igrants,
    output logic [CW-1:0] dgrants,
    output logic [CW-1:0] aborts
`endif
);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] starve_q;
    logic [CW-1:0] tcnt_q;
    logic          merr_q;

    logic [CW-1:0] starve_d;
    logic [CW-1:0] tcnt_d;

    logic          d_req;
    logic          g_req;
    logic          in_grant;
    logic          access;
    logic          done;
    logic          fault;
    logic          withdraw;

    // Increment that holds once the limit is reached.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v,
                                              input logic [CW-1:0] lim);
        return (v >= lim) ? v : v + CW'(1);
    endfunction

    assign d_req    = dREN | dWEN;
    assign in_grant = (state_q == DGRANT) || (state_q == IGRANT);
    // Request line of whichever requester currently holds the grant.
    assign g_req    = (state_q == DGRANT) ? d_req :
                      (state_q == IGRANT) ? iREN  : 1'b0;
    assign access   = (ramstate == RS_ACCESS);
    assign done     = g_req & access;
    // A timeout is handled exactly like a RAM ERROR; ACCESS in the same
    // cycle still counts as a completion.
    assign fault    = g_req & ~access &
                      ((ramstate == RS_ERROR) || (tcnt_q == CW'(TIMEOUT)));
    assign withdraw = in_grant & ~g_req;

    assign starve_d = sat_inc(starve_q, CW'(STARVE_LIMIT));
    assign tcnt_d   = sat_inc(tcnt_q, '1);

    assign iload = ramload;
    assign dload = ramload;
    assign merr  = merr_q;

    // RAM side and wait outputs are decoded from the current state. Enables
    // follow the live request so a withdrawal drops them in the same cycle.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            DGRANT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = dREN;
                end
                dwait = ~done;
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~done;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_STATS_EN
    logic [CW-1:0] igrants_q;
    logic [CW-1:0] dgrants_q;
    logic [CW-1:0] aborts_q;

    assign igrants = igrants_q;
    assign dgrants = dgrants_q;
    assign aborts  = aborts_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            igrants_q <= '0;
            dgrants_q <= '0;
            aborts_q  <= '0;
        end else begin
            if (done && state_q == DGRANT) dgrants_q <= sat_inc(dgrants_q, '1);
            if (done && state_q == IGRANT) igrants_q <= sat_inc(igrants_q, '1);
            if (withdraw || fault)         aborts_q  <= sat_inc(aborts_q, '1);
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
            tcnt_q   <= '0;
            merr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tcnt_q <= '0;
                    if (iREN && starve_q == CW'(STARVE_LIMIT)) begin
                        state_q  <= IGRANT;
                        starve_q <= '0;
                    end else if (d_req) begin
                        state_q  <= DGRANT;
                        // Only dcache wins taken over a waiting icache count.
                        starve_q <= iREN ? starve_d : '0;
                    end else if (iREN) begin
                        state_q  <= IGRANT;
                        starve_q <= '0;
                    end else begin
                        starve_q <= '0;
                    end
                end
                DGRANT, IGRANT: begin
                    if (!access) tcnt_q <= tcnt_d;
                    if (fault)   merr_q <= 1'b1;
                    // Completion, error/timeout and withdrawal all return to
                    // IDLE, which provides the turnaround cycle.
                    if (done || fault || withdraw) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter (STARVE_LIMIT=4, TIMEOUT=8, CW=8). The RAM
// status and read data are driven step by step; every expected value below is
// hand-derived from the cycle-by-cycle arbiter behaviour. Inputs change just
// after the falling edge and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        merr;
`ifdef MEM_ARB_STATS_EN
    logic [7:0]  igrants;
    logic [7:0]  dgrants;
    logic [7:0]  aborts;
`endif

    int checks   = 0;
    int failures = 0;
    int dcomp    = 0;
    int icomp    = 0;

    mem_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT     (8),
        .CW          (8)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .merr    (merr)
`ifdef MEM_ARB_STATS_EN
        ,
        .igrants (igrants),
        .dgrants (dgrants),
        .aborts  (aborts)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic nxt();
        @(negedge CLK);
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        nRST     = 1'b0;
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = RS_FREE;

        // Reset held for two edges
        repeat (2) @(posedge CLK);
        nxt(); #1;
        chk1 ("rst_iwait",   iwait,   1'b1);
        chk1 ("rst_dwait",   dwait,   1'b1);
        chk1 ("rst_ramREN",  ramREN,  1'b0);
        chk1 ("rst_ramWEN",  ramWEN,  1'b0);
        chk1 ("rst_merr",    merr,    1'b0);
        chk32("rst_ramaddr", ramaddr, 32'h0);
        nRST = 1'b1;

        // Simultaneous requests: dcache first
        nxt();
        iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; daddr = 32'h80;
        ramstate = RS_BUSY;
        #1;
        chk1 ("sim_idle_ramREN", ramREN, 1'b0);
        chk1 ("sim_idle_dwait",  dwait,  1'b1);
        nxt(); #1;
        chk1 ("sim_d1_ramREN",  ramREN,  1'b1);
        chk1 ("sim_d1_ramWEN",  ramWEN,  1'b0);
        chk32("sim_d1_ramaddr", ramaddr, 32'h80);
        chk1 ("sim_d1_dwait",   dwait,   1'b1);
        chk1 ("sim_d1_iwait",   iwait,   1'b1);
        nxt(); #1;
        chk1 ("sim_d2_dwait",   dwait,   1'b1);
        nxt(); ramstate = RS_ACCESS; ramload = 32'hDEADBEEF; #1;
        chk1 ("sim_d3_dwait",   dwait,   1'b0);
        chk32("sim_d3_dload",   dload,   32'hDEADBEEF);
        chk1 ("sim_d3_iwait",   iwait,   1'b1);
        nxt(); dREN = 1'b0; ramstate = RS_FREE; #1;
        chk1 ("sim_turn_dwait",  dwait,  1'b1);
        chk1 ("sim_turn_iwait",  iwait,  1'b1);
        chk1 ("sim_turn_ramREN", ramREN, 1'b0);
        nxt(); ramstate = RS_ACCESS; ramload = 32'hCAFEF00D; #1;
        chk32("sim_i_ramaddr", ramaddr, 32'h40);
        chk1 ("sim_i_ramREN",  ramREN,  1'b1);
        chk1 ("sim_i_iwait",   iwait,   1'b0);
        chk32("sim_i_iload",   iload,   32'hCAFEF00D);
        chk1 ("sim_i_dwait",   dwait,   1'b1);
        nxt(); iREN = 1'b0; ramstate = RS_FREE; #1;
        chk1 ("sim_end_iwait",  iwait,  1'b1);
        chk1 ("sim_end_ramREN", ramREN, 1'b0);

        // Write wins over read
        nxt();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h10; dstore = 32'h12345678;
        ramstate = RS_BUSY;
        #1;
        chk1 ("wr_idle_ramWEN", ramWEN, 1'b0);
        nxt(); #1;
        chk1 ("wr_ramWEN",   ramWEN,   1'b1);
        chk1 ("wr_ramREN",   ramREN,   1'b0);
        chk32("wr_ramstore", ramstore, 32'h12345678);
        chk32("wr_ramaddr",  ramaddr,  32'h10);
        chk1 ("wr_dwait_busy", dwait,  1'b1);
        nxt(); ramstate = RS_ACCESS; #1;
        chk1 ("wr_dwait_done", dwait,  1'b0);
        nxt(); dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE; #1;
        chk1 ("wr_end_dwait",    dwait,    1'b1);
        chk1 ("wr_end_ramWEN",   ramWEN,   1'b0);
        chk32("wr_end_ramstore", ramstore, 32'h0);

        // Starvation: both held, RAM answers on the first grant cycle.
        // Expected completion order: D D D D I, repeating.
        nxt();
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h100; iaddr = 32'h200;
        ramstate = RS_ACCESS;
        #1;
        chk1("stv_idle_dwait", dwait, 1'b1);
        for (int k = 1; k <= 19; k++) begin
            nxt(); #1;
            chk1("stv_dwait", dwait, ((k % 2) == 1 && (k % 10) != 9) ? 1'b0 : 1'b1);
            chk1("stv_iwait", iwait, ((k % 10) == 9) ? 1'b0 : 1'b1);
            if (!dwait) dcomp++;
            if (!iwait) icomp++;
        end
        chk32("stv_dcount", 32'(dcomp), 32'd8);
        chk32("stv_icount", 32'(icomp), 32'd2);
        nxt(); dREN = 1'b0; iREN = 1'b0; ramstate = RS_FREE; #1;
        chk1("stv_end_ramREN", ramREN, 1'b0);

        // Withdrawal in DGRANT
        nxt(); dREN = 1'b1; daddr = 32'h20; ramstate = RS_BUSY; #1;
        nxt(); #1;
        chk1 ("wd_ramREN_on", ramREN,  1'b1);
        chk32("wd_ramaddr",   ramaddr, 32'h20);
        nxt(); dREN = 1'b0; #1;
        chk1 ("wd_ramREN_off", ramREN, 1'b0);
        chk1 ("wd_dwait",      dwait,  1'b1);
        nxt(); #1;
        chk32("wd_idle_ramaddr", ramaddr, 32'h0);
        chk1 ("wd_idle_ramREN",  ramREN,  1'b0);
        chk1 ("wd_merr",         merr,    1'b0);

        // RAM ERROR during IGRANT, then re-grant
        nxt(); iREN = 1'b1; iaddr = 32'h44; ramstate = RS_BUSY; #1;
        nxt(); ramstate = RS_ERROR; #1;
        chk1 ("err_iwait",   iwait,   1'b1);
        chk1 ("err_ramREN",  ramREN,  1'b1);
        chk32("err_ramaddr", ramaddr, 32'h44);
        chk1 ("err_merr_pre", merr,   1'b0);
        nxt(); ramstate = RS_BUSY; #1;
        chk1 ("err_merr_set",    merr,   1'b1);
        chk1 ("err_idle_ramREN", ramREN, 1'b0);
        chk1 ("err_idle_iwait",  iwait,  1'b1);
        nxt(); ramstate = RS_ACCESS; ramload = 32'h55AA55AA; #1;
        chk1 ("err_regrant_ramREN", ramREN, 1'b1);
        chk1 ("err_regrant_iwait",  iwait,  1'b0);
        chk32("err_regrant_iload",  iload,  32'h55AA55AA);
        nxt(); iREN = 1'b0; ramstate = RS_FREE; #1;
        chk1 ("err_merr_sticky", merr,  1'b1);
        chk1 ("err_end_iwait",   iwait, 1'b1);
`ifdef MEM_ARB_STATS_EN
        chk32("stats_dgrants", 32'(dgrants), 32'd10);
        chk32("stats_igrants", 32'(igrants), 32'd4);
        chk32("stats_aborts",  32'(aborts),  32'd2);
`endif

        // Reset clears merr
        nxt(); nRST = 1'b0; #1;
        nxt(); nRST = 1'b1; #1;
        chk1("rst2_merr", merr, 1'b0);
`ifdef MEM_ARB_STATS_EN
        chk32("rst2_aborts", 32'(aborts), 32'd0);
`endif

        // Timeout: RAM stuck BUSY, grant open for TIMEOUT+1 cycles
        dREN = 1'b1; daddr = 32'h30; ramstate = RS_BUSY;
        for (int k = 1; k <= 9; k++) begin
            nxt(); #1;
            chk1("to_ramREN", ramREN, 1'b1);
            chk1("to_dwait",  dwait,  1'b1);
            chk1("to_merr",   merr,   1'b0);
        end
        nxt(); dREN = 1'b0; #1;
        chk1 ("to_idle_ramREN",  ramREN,  1'b0);
        chk32("to_idle_ramaddr", ramaddr, 32'h0);
        chk1 ("to_merr_set",     merr,    1'b1);
`ifdef MEM_ARB_STATS_EN
        chk32("to_aborts",  32'(aborts),  32'd1);
        chk32("to_dgrants", 32'(dgrants), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter/sequencer that shares one RAM port between the icache fill port and the dcache fill/writeback port of one CPU.
- Sits between the caches block and the RAM model, on the cache-to-memory side of the cache control path.
- Grants one requester at a time and holds the grant until the RAM completes or the requester withdraws.
- Drives per-requester wait/load signals. dcache has priority, with a starvation guard for icache.

Parameters:
- STARVE_LIMIT, 4: consecutive dcache grants allowed while iREN is pending before icache is forced to win the next arbitration.
- TIMEOUT, 255: maximum cycles a grant may stay open without RAM ACCESS before it is aborted.
- CW, 8: width of the timeout and stats counters.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  icache wait; low for exactly one cycle when iload is valid
- iload  out  32  icache read data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  dcache wait; low for exactly one cycle on completion
- dload  out  32  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- merr  out  1  sticky error flag, set on RAM ERROR or timeout

Behaviour:
- Reset (nRST low at CLK edge):
  - state=IDLE; starvation and timeout counters=0; merr=0.
  - All outputs are combinational functions of state, so at reset: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iload and dload are always driven from ramload.
- States: IDLE, DGRANT, IGRANT.
- IDLE:
  - No RAM enables asserted; iwait=dwait=1.
  - Next state at the edge:
    - If iREN and starve==STARVE_LIMIT: IGRANT.
    - Else if dREN or dWEN: DGRANT.
    - Else if iREN: IGRANT.
    - Else stay in IDLE.
- DGRANT:
  - ramaddr=daddr.
  - If dWEN: ramWEN=1, ramREN=0, ramstore=dstore. dWEN wins over dREN when both are high.
  - Else: ramREN=1.
- IGRANT: ramaddr=iiaddr is not used; ramaddr=iaddr, ramREN=1, ramWEN=0.
- Completion: in a grant state with ramstate==ACCESS, the granted requester's wait is 0 in that same cycle. Next state is IDLE.
- Latency: at least 1 cycle from request to grant, plus RAM time. Every transaction is followed by one IDLE turnaround cycle, so back-to-back grants are never issued.
- Withdrawal: if the granted request drops (iREN=0 in IGRANT, or dREN=dWEN=0 in DGRANT) before ACCESS, the RAM enables drop that cycle and the next state is IDLE. No wait pulse is generated and merr is unaffected.
- The non-granted requester's wait stays 1 throughout.
- ramstate==ERROR in a grant state: merr<=1, next state IDLE, and wait stays 1, so the requester re-arbitrates.
- Timeout:
  - tcnt increments each grant cycle without ACCESS and clears in IDLE.
  - When tcnt==TIMEOUT, treat as ERROR: merr<=1, go to IDLE.
  - tcnt saturates and never wraps.
- Starvation counter (starve):
  - On each IDLE->DGRANT with iREN=1: starve<=starve+1, saturating at STARVE_LIMIT.
  - On any IDLE->IGRANT, or in IDLE with iREN=0: starve<=0.
- merr clears only on reset.
- Address and data changes during a grant pass straight through. Requesters must hold them stable; the arbiter does not check.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds three outputs: igrants [CW-1:0], dgrants [CW-1:0] and aborts [CW-1:0].
  - igrants and dgrants count completed transactions (ACCESS seen) per requester.
  - aborts counts withdrawals, errors and timeouts.
  - All three reset to 0 and saturate at all-ones.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset: nRST=0 for 2 cycles -> iwait=dwait=1, ramREN=ramWEN=0, merr=0.
- Simultaneous requests: iREN=1, iaddr=0x40 and dREN=1, daddr=0x80 asserted together; RAM gives ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF.
  -> DGRANT first, ramaddr=0x80, dwait=0 for one cycle with dload=0xDEADBEEF.
  -> IDLE for one cycle.
  -> IGRANT, ramaddr=0x40, iwait pulses low once.
- Write priority: dREN=dWEN=1, daddr=0x10, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678, dwait low on ACCESS.
- Starvation: dREN held high and iREN held high, STARVE_LIMIT=4, RAM ACCESS in 1 cycle -> exactly 4 dcache completions, then one icache completion, then the pattern repeats.
- Abort and error:
  - Drop dREN mid-DGRANT -> ramREN=0 that cycle, IDLE next cycle, no dwait pulse, merr=0.
  - Separately, ramstate=ERROR during IGRANT -> merr=1 sticky, iwait stays 1, re-grant on the next arbitration.
- Timeout: TIMEOUT=8, ramstate stuck at BUSY -> grant aborted after 8 cycles, merr=1. With MEM_ARB_STATS_EN defined, aborts increments by 1.
